// File: rtl/regfile_pkg.sv
// Shared definitions for regfile_muldiv: mult/div opcodes, FSM states and divide latency.
package regfile_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    // One busy cycle per quotient bit plus the sign-fix cycle.
    function automatic int div_latency(input int width);
        return width + 1;
    endfunction

    localparam int DIV_LATENCY = div_latency(32);

endpackage

// File: rtl/md_divider.sv
// Restoring unsigned divider core: one quotient bit per cycle on magnitude operands.
module md_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_last,
    output logic [DATA_W-1:0] o_quot,
    output logic [DATA_W-1:0] o_rem
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_div;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_trial;

    // The dividend shifts out of r_quot's top while quotient bits shift in at the bottom.
    assign w_shift = {r_rem, r_quot[DATA_W-1]};
    assign w_trial = w_shift - {1'b0, r_div};
    assign o_last  = r_busy && (r_cnt == CNT_W'(1));
    assign o_quot  = r_quot;
    assign o_rem   = r_rem;

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(DATA_W);
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_div  <= i_divisor;
        end else if (r_busy) begin
            if (!w_trial[DATA_W]) begin
                r_rem  <= w_trial[DATA_W-1:0];
                r_quot <= {r_quot[DATA_W-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[DATA_W-1:0];
                r_quot <= {r_quot[DATA_W-2:0], 1'b0};
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_muldiv.sv
// Decode-stage register file with bypass, zero register, HI/LO and a sequential mult/div unit.
// Macro REGFILE_MD_DIV_EN enables the divider; without it DIV/DIVU finish in one cycle with HI=LO=0.
module regfile_muldiv
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  md_start,
    input  logic [1:0]            md_op,
    input  logic [DATA_W-1:0]     md_a,
    input  logic [DATA_W-1:0]     md_b,
    input  logic                  hi_wr,
    input  logic                  lo_wr,
    input  logic [DATA_W-1:0]     hilo_wdata,
    output logic                  md_busy,
    output logic                  md_done,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic [1:0]            o_dbg_state
);

    logic [DATA_W-1:0]   r_regs [NREG];
    md_state_t           r_state;
    md_state_t           w_next;
    logic [DATA_W-1:0]   r_hi, r_lo, r_a, r_b;
    logic                r_signed, r_done;
    logic                w_move, w_abort, w_load, w_wr_res;
    logic [DATA_W-1:0]   w_res_hi, w_res_lo;
    logic [2*DATA_W-1:0] w_ext_a, w_ext_b, w_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0) && (int'(wr_addr) < NREG)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] =
            ((w_ra == '0) || (int'(w_ra) >= NREG)) ? '0 :
            (wr_en && (wr_addr == w_ra))           ? wr_data : r_regs[w_ra];
    end

    // A move to HI/LO always wins: it aborts a running operation and blocks a new start.
    assign w_move  = hi_wr | lo_wr;
    assign w_abort = w_move && (r_state != ST_IDLE);

    assign w_ext_a = {{DATA_W{r_signed & r_a[DATA_W-1]}}, r_a};
    assign w_ext_b = {{DATA_W{r_signed & r_b[DATA_W-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

`ifdef REGFILE_MD_DIV_EN
    logic              r_q_neg, r_r_neg, r_dz;
    logic              w_div_start, w_div_last, w_sa, w_sb;
    logic [DATA_W-1:0] w_abs_a, w_abs_b, w_quot, w_rem;

    assign w_sa    = (md_op == MD_DIV) && md_a[DATA_W-1];
    assign w_sb    = (md_op == MD_DIV) && md_b[DATA_W-1];
    assign w_abs_a = w_sa ? -md_a : md_a;
    assign w_abs_b = w_sb ? -md_b : md_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_dz    <= 1'b0;
        end else if (w_div_start) begin
            r_q_neg <= w_sa ^ w_sb;
            r_r_neg <= w_sa;
            r_dz    <= (md_b == '0);
        end
    end

    md_divider #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_abort    (w_abort),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_last     (w_div_last),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );
`else
    logic r_is_div;

    always_ff @(posedge clk) begin
        if (rst)         r_is_div <= 1'b0;
        else if (w_load) r_is_div <= md_op[1];
    end
`endif

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_wr_res = 1'b0;
        w_res_hi = '0;
        w_res_lo = '0;
`ifdef REGFILE_MD_DIV_EN
        w_div_start = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (md_start && !w_move) begin
                    w_load = 1'b1;
`ifdef REGFILE_MD_DIV_EN
                    if (md_op[1]) begin
                        w_next      = ST_DIV;
                        w_div_start = 1'b1;
                    end else begin
                        w_next = ST_MUL;
                    end
`else
                    w_next = ST_MUL;
`endif
                end
            end
            ST_MUL: begin
                w_next   = ST_IDLE;
                w_wr_res = 1'b1;
`ifdef REGFILE_MD_DIV_EN
                {w_res_hi, w_res_lo} = w_prod;
`else
                if (!r_is_div) {w_res_hi, w_res_lo} = w_prod;
`endif
            end
            ST_DIV: begin
`ifdef REGFILE_MD_DIV_EN
                if (w_div_last) w_next = ST_FIX;
`else
                w_next = ST_IDLE;
`endif
            end
            ST_FIX: begin
                w_next = ST_IDLE;
`ifdef REGFILE_MD_DIV_EN
                w_wr_res = 1'b1;
                if (r_dz) begin
                    w_res_hi = r_a;
                    w_res_lo = '1;
                end else begin
                    w_res_lo = r_q_neg ? -w_quot : w_quot;
                    w_res_hi = r_r_neg ? -w_rem : w_rem;
                end
`endif
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next   = ST_IDLE;
            w_wr_res = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_wr_res;
            if (w_load) begin
                r_a      <= md_a;
                r_b      <= md_b;
                r_signed <= (md_op == MD_MULT);
            end
            if (w_wr_res) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
            if (hi_wr) r_hi <= hilo_wdata;
            if (lo_wr) r_lo <= hilo_wdata;
        end
    end

    assign md_busy     = (r_state != ST_IDLE);
    assign md_done     = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule
